// File: rtl/nf10_entropy_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// nf10_entropy_arbiter_pkg
// Shared types and helpers for the entropy input arbiter: FSM state
// encoding, flattened-bus slice helper and the rotate-priority search.
// ---------------------------------------------------------------------------
package nf10_entropy_arbiter_pkg;

   // Upper bound on requesters supported by the rotate-priority search
   localparam int unsigned MAX_PORTS = 8;

   typedef enum logic {
      IDLE = 1'b0,
      PASS = 1'b1
   } arb_state_t;

   // Low bit of slice idx in a flattened bus of width-wide slices
   function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
      return idx * width;
   endfunction

   // One-hot of the first set req bit searching upward from last+1, wrapping at num_ports
   function automatic logic [MAX_PORTS-1:0] rotate_pick(input logic [MAX_PORTS-1:0] req,
                                                         input logic [2:0]           last,
                                                         input int unsigned          num_ports);
      logic [MAX_PORTS-1:0] pick;
      logic                 found;
      logic [2:0]           idx;
      pick  = '0;
      found = 1'b0;
      for (int unsigned k = 1; k <= MAX_PORTS; k++) begin
         if (k <= num_ports) begin
            idx = 3'((32'(last) + k) % num_ports);
            if (!found && req[idx]) begin
               pick[idx] = 1'b1;
               found     = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/nf10_rr_pick.sv
// ---------------------------------------------------------------------------
// nf10_rr_pick
// Combinational round-robin selector.
//   req        : request vector, one bit per port
//   last       : index of the most recently granted port
//   pick_c     : one-hot winner (0 when no request)
//   pick_idx_c : binary index of the winner (0 when no request)
// ---------------------------------------------------------------------------
module nf10_rr_pick
   import nf10_entropy_arbiter_pkg::*;
#(
   parameter  int unsigned NUM_PORTS = 4,
   localparam int unsigned IDX_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     last,
   output logic [NUM_PORTS-1:0] pick_c,
   output logic [IDX_W-1:0]     pick_idx_c
);

   // Search and one-hot to index encode
   always_comb begin
      pick_c     = NUM_PORTS'(rotate_pick(MAX_PORTS'(req), 3'(last), NUM_PORTS));
      pick_idx_c = '0;
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
         if (pick_c[i]) pick_idx_c = IDX_W'(i);
      end
   end

endmodule

// File: rtl/nf10_entropy_arbiter.sv
// ---------------------------------------------------------------------------
// nf10_entropy_arbiter
// Packet-granular round-robin arbiter sharing the entropy block's single
// AXI4-Stream input among C_NUM_PORTS sources. The grant is held from the
// arbitration cycle through the accepted tlast beat.
//   axi_aclk, axi_resetn : clock, synchronous active-low reset
//   s_axis_*             : flattened per-port slave streams (slice i = port i)
//   m_axis_*             : stream towards the entropy instance
//   port_enable          : per-port eligibility, sampled only when arbitrating
//   grant                : one-hot current owner, 0 when idle
//   pkt_count            : flattened per-port wrapping packet counters
//   cnt_clear            : pulse that zeroes all counters (wins over increment)
// ---------------------------------------------------------------------------
module nf10_entropy_arbiter
   import nf10_entropy_arbiter_pkg::*;
#(
   parameter int unsigned C_NUM_PORTS        = 4,
   parameter int unsigned C_AXIS_DATA_WIDTH  = 256,
   parameter int unsigned C_AXIS_TUSER_WIDTH = 128,
   parameter int unsigned C_CNT_WIDTH        = 32
) (
   input  logic                                         axi_aclk,
   input  logic                                         axi_resetn,
   input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [C_NUM_PORTS*C_AXIS_DATA_WIDTH/8-1:0]   s_axis_tstrb,
   input  logic [C_NUM_PORTS*C_AXIS_TUSER_WIDTH-1:0]    s_axis_tuser,
   input  logic [C_NUM_PORTS-1:0]                       s_axis_tvalid,
   input  logic [C_NUM_PORTS-1:0]                       s_axis_tlast,
   output logic [C_NUM_PORTS-1:0]                       s_axis_tready,
   output logic [C_AXIS_DATA_WIDTH-1:0]                 m_axis_tdata,
   output logic [C_AXIS_DATA_WIDTH/8-1:0]               m_axis_tstrb,
   output logic [C_AXIS_TUSER_WIDTH-1:0]                m_axis_tuser,
   output logic                                         m_axis_tvalid,
   output logic                                         m_axis_tlast,
   input  logic                                         m_axis_tready,
   input  logic [C_NUM_PORTS-1:0]                       port_enable,
   output logic [C_NUM_PORTS-1:0]                       grant,
   output logic [C_NUM_PORTS*C_CNT_WIDTH-1:0]           pkt_count,
   input  logic                                         cnt_clear
);

   localparam int unsigned STRB_W = C_AXIS_DATA_WIDTH / 8;
   localparam int unsigned IDX_W  = (C_NUM_PORTS > 1) ? $clog2(C_NUM_PORTS) : 1;

   arb_state_t             state;
   logic [IDX_W-1:0]       last;
   logic [C_NUM_PORTS-1:0] req;
   logic [C_NUM_PORTS-1:0] pick_c;
   logic [IDX_W-1:0]       pick_idx_c;
   logic                   last_beat_c;
   logic [C_CNT_WIDTH-1:0] cnt [C_NUM_PORTS];

   assign req = s_axis_tvalid & port_enable;

   nf10_rr_pick #(
      .NUM_PORTS (C_NUM_PORTS)
   ) u_pick (
      .req        (req),
      .last       (last),
      .pick_c     (pick_c),
      .pick_idx_c (pick_idx_c)
   );

   // Zero-latency mux off the registered grant; grant is 0 in IDLE so the
   // master side is quiet and every tready is low there.
   always_comb begin
      m_axis_tdata  = '0;
      m_axis_tstrb  = '0;
      m_axis_tuser  = '0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      for (int unsigned i = 0; i < C_NUM_PORTS; i++) begin
         if (grant[i]) begin
            m_axis_tdata  = s_axis_tdata[slice_lo(i, C_AXIS_DATA_WIDTH)  +: C_AXIS_DATA_WIDTH];
            m_axis_tstrb  = s_axis_tstrb[slice_lo(i, STRB_W)             +: STRB_W];
            m_axis_tuser  = s_axis_tuser[slice_lo(i, C_AXIS_TUSER_WIDTH) +: C_AXIS_TUSER_WIDTH];
            m_axis_tvalid = s_axis_tvalid[i];
            m_axis_tlast  = s_axis_tlast[i];
         end
      end
   end

   assign s_axis_tready = grant & {C_NUM_PORTS{m_axis_tready}};
   assign last_beat_c   = (state == PASS) & m_axis_tvalid & m_axis_tready & m_axis_tlast;

   // Arbitration FSM and packet counters
   always_ff @(posedge axi_aclk) begin
      if (!axi_resetn) begin
         state <= IDLE;
         grant <= '0;
         last  <= IDX_W'(C_NUM_PORTS - 1);
         for (int unsigned i = 0; i < C_NUM_PORTS; i++) cnt[i] <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (|req) begin
                  grant <= pick_c;
                  last  <= pick_idx_c;
                  state <= PASS;
               end
            end
            PASS: begin
               if (last_beat_c) begin
                  grant <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         for (int unsigned i = 0; i < C_NUM_PORTS; i++) begin
            if (cnt_clear)                  cnt[i] <= '0;
            else if (last_beat_c && grant[i]) cnt[i] <= cnt[i] + C_CNT_WIDTH'(1);
         end
      end
   end

   for (genvar gi = 0; gi < C_NUM_PORTS; gi++) begin : g_cnt
      assign pkt_count[gi*C_CNT_WIDTH +: C_CNT_WIDTH] = cnt[gi];
   end

endmodule

// File: tb/tb_nf10_entropy_arbiter.sv
// ---------------------------------------------------------------------------
// tb_nf10_entropy_arbiter
// Directed scoreboard bench: per-port source queues feed the DUT, expected
// beats are queued in hand-derived grant order and checked by a monitor.
// A 4-bit counter width makes the wrap case reachable.
// ---------------------------------------------------------------------------
module tb_nf10_entropy_arbiter;

   localparam int NP = 4;
   localparam int DW = 256;
   localparam int SW = DW / 8;
   localparam int UW = 128;
   localparam int CW = 4;

   typedef struct packed {
      logic [NP-1:0] grant;
      logic          last;
      logic [SW-1:0] strb;
      logic [UW-1:0] user;
      logic [DW-1:0] data;
   } beat_t;

   logic              clk = 1'b0;
   logic              axi_resetn;
   logic [NP*DW-1:0]  s_axis_tdata;
   logic [NP*SW-1:0]  s_axis_tstrb;
   logic [NP*UW-1:0]  s_axis_tuser;
   logic [NP-1:0]     s_axis_tvalid;
   logic [NP-1:0]     s_axis_tlast;
   logic [NP-1:0]     s_axis_tready;
   logic [DW-1:0]     m_axis_tdata;
   logic [SW-1:0]     m_axis_tstrb;
   logic [UW-1:0]     m_axis_tuser;
   logic              m_axis_tvalid;
   logic              m_axis_tlast;
   logic              m_axis_tready;
   logic [NP-1:0]     port_enable;
   logic [NP-1:0]     grant;
   logic [NP*CW-1:0]  pkt_count;
   logic              cnt_clear;

   beat_t src_q [NP][$];
   beat_t exp_q [$];
   int    n_checks = 0;
   int    n_fail   = 0;

   always #5 clk = ~clk;

   nf10_entropy_arbiter #(
      .C_NUM_PORTS        (NP),
      .C_AXIS_DATA_WIDTH  (DW),
      .C_AXIS_TUSER_WIDTH (UW),
      .C_CNT_WIDTH        (CW)
   ) dut (
      .axi_aclk      (clk),
      .axi_resetn    (axi_resetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tstrb  (s_axis_tstrb),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tstrb  (m_axis_tstrb),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .port_enable   (port_enable),
      .grant         (grant),
      .pkt_count     (pkt_count),
      .cnt_clear     (cnt_clear)
   );

   function automatic beat_t make_beat(input int p, input int id, input int b, input bit lst);
      beat_t       t;
      logic [31:0] w;
      w       = {8'(p), 8'(id), 8'(b), 8'hA5};
      t.grant = NP'(1 << p);
      t.last  = lst;
      t.strb  = w ^ 32'hFFFF_0000;
      t.user  = {4{~w}};
      t.data  = {8{w}};
      return t;
   endfunction

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_ports();
      for (int i = 0; i < NP; i++) begin
         if (src_q[i].size() > 0) begin
            s_axis_tdata[i*DW +: DW] = src_q[i][0].data;
            s_axis_tstrb[i*SW +: SW] = src_q[i][0].strb;
            s_axis_tuser[i*UW +: UW] = src_q[i][0].user;
            s_axis_tlast[i]          = src_q[i][0].last;
            s_axis_tvalid[i]         = 1'b1;
         end else begin
            s_axis_tdata[i*DW +: DW] = '0;
            s_axis_tstrb[i*SW +: SW] = '0;
            s_axis_tuser[i*UW +: UW] = '0;
            s_axis_tlast[i]          = 1'b0;
            s_axis_tvalid[i]         = 1'b0;
         end
      end
   endtask

   task automatic send_pkt(input int p, input int n, input int id);
      for (int b = 0; b < n; b++) src_q[p].push_back(make_beat(p, id, b, b == n - 1));
      drive_ports();
   endtask

   task automatic exp_pkt(input int p, input int n, input int id);
      for (int b = 0; b < n; b++) exp_q.push_back(make_beat(p, id, b, b == n - 1));
   endtask

   task automatic wait_idle(input int budget, output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (!(exp_q.size() == 0 && grant == '0) && cycles < budget);
      if (!(exp_q.size() == 0 && grant == '0)) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_idle timeout: pending %0d grant %b after %0d cycles", exp_q.size(), grant, cycles);
      end
   endtask

   task automatic chk_counts(input string nm, input int c0, input int c1, input int c2, input int c3);
      chk({nm, "_p0"}, 512'(pkt_count[0*CW +: CW]), 512'(c0));
      chk({nm, "_p1"}, 512'(pkt_count[1*CW +: CW]), 512'(c1));
      chk({nm, "_p2"}, 512'(pkt_count[2*CW +: CW]), 512'(c2));
      chk({nm, "_p3"}, 512'(pkt_count[3*CW +: CW]), 512'(c3));
   endtask

   // Source driver: retire beats that handshook at the last edge, present next heads
   initial begin
      logic [NP-1:0] fire;
      forever begin
         @(negedge clk);
         fire = s_axis_tvalid & s_axis_tready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NP; i++) begin
            if (fire[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
         end
         drive_ports();
      end
   end

   // Monitor: every accepted master beat must match the head of the scoreboard
   initial begin
      beat_t act;
      beat_t e;
      forever begin
         @(negedge clk);
         if (axi_resetn && m_axis_tvalid && m_axis_tready) begin
            act = '{grant: grant, last: m_axis_tlast, strb: m_axis_tstrb,
                    user: m_axis_tuser, data: m_axis_tdata};
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_beat at %0t: grant %b data %0h", $time, grant, m_axis_tdata);
            end else begin
               e = exp_q.pop_front();
               chk("beat", 512'(act), 512'(e));
               chk("s_tready", 512'(s_axis_tready), 512'(e.grant));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int    cyc;
      int    got;
      beat_t b1;

      axi_resetn    = 1'b0;
      m_axis_tready = 1'b1;
      port_enable   = 4'b1111;
      cnt_clear     = 1'b0;
      drive_ports();
      repeat (3) tick();
      chk("reset_state", 512'({grant, m_axis_tvalid, s_axis_tready, pkt_count}), 512'(0));
      axi_resetn = 1'b1;
      tick();

      // All four ports, 3-beat packets: rotation 0,1,2,3 at 4 cycles per packet
      for (int p = 0; p < NP; p++) begin
         send_pkt(p, 3, 10 + p);
         exp_pkt(p, 3, 10 + p);
      end
      wait_idle(40, cyc);
      chk("rotation_cycles", 512'(cyc), 512'(16));
      chk_counts("cnt_rot", 1, 1, 1, 1);

      // Port 2 alone, five single-beat packets: grant toggles 0100 / 0
      for (int k = 0; k < 5; k++) begin
         send_pkt(2, 1, 20 + k);
         exp_pkt(2, 1, 20 + k);
      end
      for (int c = 1; c <= 10; c++) begin
         tick();
         chk("single_toggle", 512'(grant), 512'((c % 2 == 1) ? 4'b0100 : 4'b0000));
      end
      chk("single_drained", 512'(exp_q.size()), 512'(0));
      chk("cnt_single_p2", 512'(pkt_count[2*CW +: CW]), 512'(6));

      // Port 1 stalled mid-packet for 7 cycles
      send_pkt(1, 3, 30);
      exp_pkt(1, 3, 30);
      b1 = make_beat(1, 30, 1, 1'b0);
      tick();
      tick();
      m_axis_tready = 1'b0;
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         chk("stall_hold", 512'({m_axis_tvalid, s_axis_tready, grant, m_axis_tdata}),
             512'({1'b1, 4'b0000, 4'b0010, b1.data}));
         tick();
      end
      m_axis_tready = 1'b1;
      wait_idle(20, cyc);
      chk("cnt_stall_p1", 512'(pkt_count[1*CW +: CW]), 512'(2));

      // Enable 1011 with last=1: order 3,0,1 and port 2 stays pending
      port_enable = 4'b1011;
      for (int p = 0; p < NP; p++) send_pkt(p, 2, 40 + p);
      exp_pkt(3, 2, 43);
      exp_pkt(0, 2, 40);
      exp_pkt(1, 2, 41);
      wait_idle(40, cyc);
      chk("masked_cycles", 512'(cyc), 512'(9));

      // Drop port 1's enable inside its packet: packet still completes
      send_pkt(1, 3, 50);
      exp_pkt(1, 3, 50);
      got = 0;
      for (int c = 0; c < 6 && got == 0; c++) begin
         tick();
         if (grant == 4'b0010) got = 1;
      end
      chk("en_drop_granted", 512'(got), 512'(1));
      tick();
      port_enable = 4'b1001;
      send_pkt(1, 1, 51);
      wait_idle(20, cyc);
      repeat (4) tick();
      chk("disabled_no_grant", 512'(grant), 512'(0));
      port_enable = 4'b1111;
      exp_pkt(2, 2, 42);
      exp_pkt(1, 1, 51);
      wait_idle(30, cyc);
      chk_counts("cnt_mask", 2, 5, 7, 2);

      // Reset during beat 2 of a 4-beat packet
      send_pkt(0, 4, 60);
      exp_pkt(0, 4, 60);
      tick();
      tick();
      tick();
      axi_resetn    = 1'b0;
      m_axis_tready = 1'b0;
      tick();
      chk("trunc_pending", 512'(exp_q.size()), 512'(2));
      chk("reset_mid_pkt", 512'({grant, m_axis_tvalid, s_axis_tready, pkt_count}), 512'(0));
      exp_q.delete();
      for (int p = 0; p < NP; p++) src_q[p].delete();
      drive_ports();
      axi_resetn    = 1'b1;
      m_axis_tready = 1'b1;
      tick();
      for (int p = 0; p < NP; p++) begin
         send_pkt(p, 1, 70 + p);
         exp_pkt(p, 1, 70 + p);
      end
      wait_idle(30, cyc);
      chk("post_reset_cycles", 512'(cyc), 512'(8));
      chk_counts("cnt_post_reset", 1, 1, 1, 1);

      // Counter wrap: 15 more packets on port 0 take it 1 -> 16 -> 0
      for (int k = 0; k < 15; k++) begin
         send_pkt(0, 1, 80 + k);
         exp_pkt(0, 1, 80 + k);
      end
      wait_idle(60, cyc);
      chk("wrap_cycles", 512'(cyc), 512'(30));
      chk("cnt_wrap_p0", 512'(pkt_count[0*CW +: CW]), 512'(0));
      for (int k = 0; k < 3; k++) begin
         send_pkt(0, 1, 100 + k);
         exp_pkt(0, 1, 100 + k);
      end
      wait_idle(20, cyc);
      chk("cnt_after_wrap_p0", 512'(pkt_count[0*CW +: CW]), 512'(3));

      // cnt_clear on the same edge as a tlast acceptance: clear wins
      send_pkt(0, 1, 110);
      exp_pkt(0, 1, 110);
      tick();
      cnt_clear = 1'b1;
      tick();
      cnt_clear = 1'b0;
      chk_counts("cnt_clear_win", 0, 0, 0, 0);
      wait_idle(10, cyc);

      chk("scoreboard_drained", 512'(exp_q.size()), 512'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
